// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS control FSM with a request/ready memory handshake, a wait-state timeout fault and a debug state output.
// Optional performance counters (Cycle_Count, Instr_Count) are enabled by defining MC_PERF_CNT_EN.
module mips_mc_control #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = 4,
  parameter int FAULT_HALT  = 1
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [5:0]  i_opcode,
  input  logic [5:0]  i_funct,
  input  logic        i_zero,
  input  logic        i_mem_ready,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic        o_iord,
  output logic        o_ir_write,
  output logic        o_pc_write,
  output logic        o_reg_write,
  output logic [1:0]  o_reg_dstn,
  output logic [1:0]  o_mem_to_reg,
  output logic        o_alu_srca,
  output logic [1:0]  o_alu_srcb,
  output logic [2:0]  o_alu_op,
  output logic [1:0]  o_pc_source,
  output logic        o_fault,
  output logic [3:0]  o_state
`ifdef MC_PERF_CNT_EN
  ,
  output logic [31:0] o_cycle_count,
  output logic [31:0] o_instr_count
`endif
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    R_EXEC    = 4'd6,
    R_WB      = 4'd7,
    BRANCH    = 4'd8,
    JUMP      = 4'd9,
    JAL       = 4'd10,
    JR        = 4'd11,
    ADDI_EXEC = 4'd12,
    ADDI_WB   = 4'd13,
    HALT      = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;

  // The access times out on the wait cycle that would bring the counter to MEM_TIMEOUT.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  state_t          r_state;
  state_t          w_next;
  logic [TO_W-1:0] r_wait_cnt;
  logic            r_fault;
  logic            w_fault;
  logic            w_mem_wait;
  logic            w_timeout;

  always_comb begin
    w_mem_wait = (r_state == FETCH) || (r_state == MEM_READ) || (r_state == MEM_WRITE);
    w_timeout  = w_mem_wait && !i_mem_ready && (r_wait_cnt == TO_LAST);
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state    <= FETCH;
      r_wait_cnt <= '0;
      r_fault    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_fault) r_fault <= 1'b1;
      if (w_fault || (w_next != r_state)) r_wait_cnt <= '0;
      else if (w_mem_wait && !i_mem_ready) r_wait_cnt <= r_wait_cnt + TO_W'(1);
    end
  end

  always_comb begin
    w_next  = r_state;
    w_fault = 1'b0;
    case (r_state)
      FETCH: begin
        if (i_mem_ready)    w_next  = DECODE;
        else if (w_timeout) w_fault = 1'b1;
      end
      DECODE: begin
        case (i_opcode)
          OP_LW, OP_SW:    w_next = MEM_ADDR;
          OP_RTYPE:        w_next = (i_funct == FN_JR) ? JR : R_EXEC;
          OP_BEQ, OP_BNE:  w_next = BRANCH;
          OP_ADDI:         w_next = ADDI_EXEC;
          OP_J:            w_next = JUMP;
          OP_JAL:          w_next = JAL;
          default:         w_fault = 1'b1;
        endcase
      end
      MEM_ADDR:  w_next = (i_opcode == OP_LW) ? MEM_READ : MEM_WRITE;
      MEM_READ: begin
        if (i_mem_ready)    w_next  = MEM_WB;
        else if (w_timeout) w_fault = 1'b1;
      end
      MEM_WRITE: begin
        if (i_mem_ready)    w_next  = FETCH;
        else if (w_timeout) w_fault = 1'b1;
      end
      R_EXEC:    w_next = R_WB;
      ADDI_EXEC: w_next = ADDI_WB;
      MEM_WB, R_WB, ADDI_WB, BRANCH, JUMP, JAL, JR: w_next = FETCH;
      HALT:      w_next = HALT;
      default:   w_next = FETCH;
    endcase
    if (w_fault) w_next = (FAULT_HALT != 0) ? HALT : FETCH;
  end

  always_comb begin
    o_mem_req    = 1'b0;
    o_mem_we     = 1'b0;
    o_iord       = 1'b0;
    o_ir_write   = 1'b0;
    o_pc_write   = 1'b0;
    o_reg_write  = 1'b0;
    o_reg_dstn   = 2'b00;
    o_mem_to_reg = 2'b00;
    o_alu_srca   = 1'b0;
    o_alu_srcb   = 2'b00;
    o_alu_op     = ALU_ADD;
    o_pc_source  = 2'b00;
    if (i_reset_n) begin
      case (r_state)
        FETCH: begin
          o_mem_req = 1'b1;
          if (i_mem_ready) begin
            o_ir_write = 1'b1;
            o_pc_write = 1'b1;
            o_alu_srcb = 2'b01;
          end
        end
        DECODE:   o_alu_srcb = 2'b11;
        MEM_ADDR: begin
          o_alu_srca = 1'b1;
          o_alu_srcb = 2'b10;
        end
        MEM_READ: begin
          o_mem_req = 1'b1;
          o_iord    = 1'b1;
        end
        MEM_WB: begin
          o_reg_write  = 1'b1;
          o_mem_to_reg = 2'b01;
        end
        MEM_WRITE: begin
          o_mem_req = 1'b1;
          o_mem_we  = 1'b1;
          o_iord    = 1'b1;
        end
        R_EXEC: begin
          o_alu_srca = 1'b1;
          o_alu_op   = ALU_FUNCT;
        end
        R_WB: begin
          o_reg_write = 1'b1;
          o_reg_dstn  = 2'b01;
        end
        ADDI_EXEC: begin
          o_alu_srca = 1'b1;
          o_alu_srcb = 2'b10;
        end
        ADDI_WB:  o_reg_write = 1'b1;
        BRANCH: begin
          o_alu_srca  = 1'b1;
          o_alu_op    = ALU_SUB;
          o_pc_source = 2'b01;
          o_pc_write  = ((i_opcode == OP_BEQ) && i_zero) || ((i_opcode == OP_BNE) && !i_zero);
        end
        JUMP: begin
          o_pc_write  = 1'b1;
          o_pc_source = 2'b10;
        end
        JAL: begin
          o_pc_write   = 1'b1;
          o_pc_source  = 2'b10;
          o_reg_write  = 1'b1;
          o_reg_dstn   = 2'b10;
          o_mem_to_reg = 2'b10;
        end
        JR: begin
          o_pc_write  = 1'b1;
          o_pc_source = 2'b11;
        end
        default: ;
      endcase
    end
  end

  assign o_fault = r_fault;
  assign o_state = r_state;

`ifdef MC_PERF_CNT_EN
  logic [31:0] r_cycle_count;
  logic [31:0] r_instr_count;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_cycle_count <= '0;
      r_instr_count <= '0;
    end else begin
      if (r_state != HALT) r_cycle_count <= r_cycle_count + 32'd1;
      if ((w_next == FETCH) && (r_state != FETCH) && !w_fault) r_instr_count <= r_instr_count + 32'd1;
    end
  end

  assign o_cycle_count = r_cycle_count;
  assign o_instr_count = r_instr_count;
`endif

endmodule
